serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fa.sv | 13 +
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

    localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell, purely combinational; the only arithmetic in the adder.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused once per clock, LSB first.
//
//   state | meaning
//   IDLE  | waiting for start; sum/cout hold the last result
//   SHIFT | one bit pair per cycle through the FA cell, cnt counts bits done
//   DONE  | one-cycle done pulse; start here reloads for back-to-back issue
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // An out-of-range WIDTH instantiates a module that does not exist, stopping elaboration.
    if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
        serial_adder_width_out_of_range u_bad ();
    end

    sa_state_t        state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] s_next;

    serial_adder_fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    // Written as shifts rather than a concatenation so WIDTH=1 needs no empty slice.
    assign s_next = (s_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    // Sequencer, operand/sum shift registers, carry flop, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_next;
                    carry <= fa_co;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= s_next;
                        cout  <= fa_co;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random traffic
// compared every cycle against a transaction-level model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_errors = 0;
    int n_done_seen = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Transaction model: an accepted request completes exactly W edges later with a+b+cin.
    logic         m_active = 1'b0;
    int           m_age    = 0;
    logic [W:0]   m_res    = '0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_sum  <= '0;
            exp_cout <= 1'b0;
        end else if (!m_active) begin
            exp_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1;
                m_age    <= 1;
                m_res    <= {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                exp_busy <= 1'b1;
            end else begin
                exp_busy <= 1'b0;
            end
        end else if (m_age == W) begin
            m_active <= 1'b0;
            exp_busy <= 1'b0;
            exp_done <= 1'b1;
            exp_sum  <= m_res[W-1:0];
            exp_cout <= m_res[W];
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("sum", sum, exp_sum);
        chk("cout", cout, exp_cout);
        chk("busy_done_excl", busy & done, 1'b0);
        if (done) n_done_seen++;
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = busy ? 1 : 0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (done) break;
            if (busy) busy_cnt++;
        end
        if (!done) chk("done_timeout", done, 1'b1);
    endtask

    int cyc;
    int bcnt;
    int dones;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_sum", sum, 8'h00);
            chk("idle_cout", cout, 1'b0);
        end

        issue(8'h12, 8'h34, 1'b0);
        wait_done(cyc, bcnt);
        chk("lat_12_34", cyc, 8);
        chk("busy_len_12_34", bcnt, 8);
        chk("sum_12_34", sum, 8'h46);
        chk("cout_12_34", cout, 1'b0);
        chk("model_sum_12_34", exp_sum, 8'h46);
        @(negedge clk);

        issue(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bcnt);
        chk("sum_ff_01", sum, 8'h00);
        chk("cout_ff_01", cout, 1'b1);
        chk("model_cout_ff_01", exp_cout, 1'b1);
        @(negedge clk);

        issue(8'h5A, 8'hA5, 1'b1);
        wait_done(cyc, bcnt);
        chk("sum_5a_a5", sum, 8'h00);
        chk("cout_5a_a5", cout, 1'b1);

        // Back-to-back: first result, then start during its DONE cycle.
        @(negedge clk);
        issue(8'h0F, 8'h01, 1'b0);
        wait_done(cyc, bcnt);
        chk("sum_0f_01", sum, 8'h10);
        issue(8'h80, 8'h80, 1'b0);
        chk("b2b_hold_sum", sum, 8'h10);
        chk("b2b_busy", busy, 1'b1);
        wait_done(cyc, bcnt);
        chk("b2b_lat", cyc, 8);
        chk("b2b_sum", sum, 8'h00);
        chk("b2b_cout", cout, 1'b1);
        @(negedge clk);

        // Start pulsed during SHIFT must be ignored.
        issue(8'h33, 8'h44, 1'b0);
        repeat (2) @(negedge clk);
        issue(8'h01, 8'h01, 1'b0);
        wait_done(cyc, bcnt);
        chk("ign_lat", cyc, 5);
        chk("ign_sum", sum, 8'h77);
        chk("ign_cout", cout, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("ign_no_second_done", dones, 0);
        chk("ign_sum_held", sum, 8'h77);

        // Asynchronous reset in the middle of SHIFT.
        issue(8'h11, 8'h22, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done | busy) dones++;
        end
        chk("rst_no_done", dones, 0);
        issue(8'hC8, 8'h64, 1'b1);
        wait_done(cyc, bcnt);
        chk("post_rst_lat", cyc, 8);
        chk("post_rst_sum", sum, 8'h2D);
        chk("post_rst_cout", cout, 1'b1);

        // Random traffic: idle gaps, back-to-back issue, starts during SHIFT, one mid-run reset.
        n_done_seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom_range(0, 1));
            if (i == 1000) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("rand_activity", (n_done_seen > 50) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
